debounce_multi: RTL and testbench



---
 rtl/debounce_multi.sv | 158 +++++++++++++++
 tb/tb_debounce_multi.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel button conditioner. Each channel has a two-flop synchroniser,
// a stability counter, a debounced level, and press/release/long-press/auto-repeat pulses.
module debounce_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_MAX    = 999_999,
    parameter int LONG_CNT   = 49_999_999,
    parameter int REPEAT_CNT = 9_999_999,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_flag,
    output logic [N_CH-1:0] release_flag,
    output logic [N_CH-1:0] long_flag,
    output logic [N_CH-1:0] repeat_flag
);

    localparam int DW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int LW = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;
    localparam int RW = (REPEAT_CNT > 0) ? $clog2(REPEAT_CNT + 1) : 1;
    // One hold counter serves both the long-press and the repeat interval.
    localparam int HW = (LW > RW) ? LW : RW;

    localparam logic [DW-1:0] DC_TC   = DW'(CNT_MAX);
    localparam logic [HW-1:0] LONG_TC = HW'(LONG_CNT);
    localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CNT);
    localparam logic          REP_EN  = (REPEAT_CNT != 0);
    localparam logic          IDLE_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        LONG
    } hold_state_t;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic          sync1_reg;
        logic          sync2_reg;
        logic          level_reg;
        logic          press_reg;
        logic          release_reg;
        logic          long_reg;
        logic          repeat_reg;
        logic [DW-1:0] dcnt_reg;

        logic          s;
        logic          differ;
        logic          settle;
        logic          press_evt;
        logic          release_evt;

        hold_state_t   state_reg;
        hold_state_t   state_next;
        logic [HW-1:0] hcnt_reg;
        logic [HW-1:0] hcnt_next;
        logic          long_next;
        logic          repeat_next;

        assign s           = ACTIVE_LOW ? ~sync2_reg : sync2_reg;
        assign differ      = s ^ level_reg;
        assign settle      = differ && (dcnt_reg == DC_TC);
        assign press_evt   = settle && s;
        assign release_evt = settle && !s;

        // Synchroniser and stability counter; any agreeing sample restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_reg   <= IDLE_LVL;
                sync2_reg   <= IDLE_LVL;
                level_reg   <= 1'b0;
                dcnt_reg    <= '0;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
            end else begin
                sync1_reg   <= btn_in[gi];
                sync2_reg   <= sync1_reg;
                press_reg   <= press_evt;
                release_reg <= release_evt;
                if (!differ) begin
                    dcnt_reg <= '0;
                end else if (settle) begin
                    dcnt_reg  <= '0;
                    level_reg <= ~level_reg;
                end else begin
                    dcnt_reg <= dcnt_reg + DW'(1);
                end
            end
        end

        // Hold tracking keys off the settle events so a release on a terminal count wins.
        always_comb begin
            state_next  = state_reg;
            hcnt_next   = hcnt_reg;
            long_next   = 1'b0;
            repeat_next = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (press_evt) begin
                        state_next = HOLD;
                        hcnt_next  = '0;
                    end
                end
                HOLD: begin
                    if (hcnt_reg == LONG_TC) begin
                        long_next  = 1'b1;
                        hcnt_next  = '0;
                        state_next = LONG;
                    end else begin
                        hcnt_next = hcnt_reg + HW'(1);
                    end
                end
                LONG: begin
                    if (!REP_EN) begin
                        hcnt_next = '0;
                    end else if (hcnt_reg == REP_TC) begin
                        repeat_next = 1'b1;
                        hcnt_next   = '0;
                    end else begin
                        hcnt_next = hcnt_reg + HW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    hcnt_next  = '0;
                end
            endcase
            if (release_evt) begin
                state_next  = IDLE;
                hcnt_next   = '0;
                long_next   = 1'b0;
                repeat_next = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg  <= IDLE;
                hcnt_reg   <= '0;
                long_reg   <= 1'b0;
                repeat_reg <= 1'b0;
            end else begin
                state_reg  <= state_next;
                hcnt_reg   <= hcnt_next;
                long_reg   <= long_next;
                repeat_reg <= repeat_next;
            end
        end

        assign btn_level[gi]    = level_reg;
        assign press_flag[gi]   = press_reg;
        assign release_flag[gi] = release_reg;
        assign long_flag[gi]    = long_reg;
        assign repeat_flag[gi]  = repeat_reg;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: timestamp-based reference model compared every cycle,
// directed scenarios with hand-computed latencies, then randomized button activity.
module tb_debounce_multi;
    localparam int N  = 4;
    localparam int CM = 19;
    localparam int LC = 99;
    localparam int RC = 49;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '1;
    logic [N-1:0] btn_level, press_flag, release_flag, long_flag, repeat_flag;

    debounce_multi #(
        .N_CH      (N),
        .CNT_MAX   (CM),
        .LONG_CNT  (LC),
        .REPEAT_CNT(RC),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .press_flag  (press_flag),
        .release_flag(release_flag),
        .long_flag   (long_flag),
        .repeat_flag (repeat_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit model_valid = 0;

    // Reference model state: delayed samples plus event timestamps.
    bit d0 [N];
    bit d1 [N];
    bit m_level [N];
    int run_start [N];
    bit active [N];
    bit in_long [N];
    int long_due [N];
    int rep_due [N];
    logic [N-1:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0, e_rep = '0;

    // Observed event bookkeeping.
    int press_cnt [N] = '{default: 0};
    int rel_cnt [N] = '{default: 0};
    int long_cnt [N] = '{default: 0};
    int rep_cnt [N] = '{default: 0};
    int press_t [N] = '{default: 0};
    int rel_t [N] = '{default: 0};
    int long_t [N] = '{default: 0};
    int rep_t [N] = '{default: 0};
    logic [N-1:0] last_press_vec = '0;

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit s;
            bit pr;
            bit rl;
            pr = 0;
            rl = 0;
            e_long[c] = 1'b0;
            e_rep[c]  = 1'b0;
            if (rst) begin
                d0[c] = 0; d1[c] = 0; m_level[c] = 0;
                run_start[c] = cyc + 1;
                active[c] = 0; in_long[c] = 0;
                e_level[c] = 0; e_press[c] = 0; e_rel[c] = 0;
                continue;
            end
            // The level seen by the counter at this edge was sampled two edges ago.
            s = d1[c];
            d1[c] = d0[c];
            d0[c] = !btn_in[c];
            if (s == m_level[c]) begin
                run_start[c] = cyc + 1;
            end else if (cyc - run_start[c] == CM) begin
                m_level[c] = s;
                run_start[c] = cyc + 1;
                if (s) pr = 1; else rl = 1;
            end
            if (rl) begin
                active[c] = 0;
                in_long[c] = 0;
            end else if (pr) begin
                active[c] = 1;
                in_long[c] = 0;
                long_due[c] = cyc + LC + 1;
            end else if (active[c]) begin
                if (!in_long[c] && cyc == long_due[c]) begin
                    e_long[c] = 1'b1;
                    in_long[c] = 1;
                    rep_due[c] = cyc + RC + 1;
                end else if (in_long[c] && RC != 0 && cyc == rep_due[c]) begin
                    e_rep[c] = 1'b1;
                    rep_due[c] = cyc + RC + 1;
                end
            end
            e_press[c] = pr;
            e_rel[c]   = rl;
            e_level[c] = m_level[c];
        end
        if (rst) model_valid = 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("btn_level", 32'(btn_level), 32'(e_level));
                chk("press_flag", 32'(press_flag), 32'(e_press));
                chk("release_flag", 32'(release_flag), 32'(e_rel));
                chk("long_flag", 32'(long_flag), 32'(e_long));
                chk("repeat_flag", 32'(repeat_flag), 32'(e_rep));
            end
            if (press_flag !== '0) last_press_vec = press_flag;
            for (int c = 0; c < N; c++) begin
                if (press_flag[c] === 1'b1)   begin press_cnt[c]++; press_t[c] = cyc; end
                if (release_flag[c] === 1'b1) begin rel_cnt[c]++;   rel_t[c]   = cyc; end
                if (long_flag[c] === 1'b1)    begin long_cnt[c]++;  long_t[c]  = cyc; end
                if (repeat_flag[c] === 1'b1)  begin rep_cnt[c]++;   rep_t[c]   = cyc; end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int cnt_of(input int kind, input int ch);
        case (kind)
            0: return press_cnt[ch];
            1: return rel_cnt[ch];
            default: return long_cnt[ch];
        endcase
    endfunction

    task automatic wait_evt(input int kind, input int ch, input int base, input string nm);
        for (int i = 0; i < 400; i++) begin
            if (cnt_of(kind, ch) > base) return;
            tick(1);
        end
        total++;
        bad++;
        $display("FAIL %s timeout cyc=%0d got=none want=event", nm, cyc);
    endtask

    initial begin
        int e_edge, base, tp, r_edge, rb, lb, others;

        rst = 1'b1;
        btn_in = '1;
        tick(3);
        chk("reset_outputs", 32'({btn_level, press_flag, release_flag, long_flag, repeat_flag}), 32'd0);
        rst = 1'b0;
        tick(30);

        // 1: bounce then hold low on channel 0
        base = press_cnt[0];
        others = press_cnt[1] + press_cnt[2] + press_cnt[3];
        btn_in[0] = 1'b0; tick(3);
        btn_in[0] = 1'b1; tick(3);
        btn_in[0] = 1'b0; tick(3);
        btn_in[0] = 1'b1; tick(3);
        btn_in[0] = 1'b0;
        e_edge = cyc + 1;
        wait_evt(0, 0, base, "t1_press");
        chk("t1_latency", 32'(press_t[0] - e_edge), 32'd21);
        tick(5);
        chk("t1_press_count", 32'(press_cnt[0] - base), 32'd1);
        chk("t1_level", 32'(btn_level[0]), 32'd1);
        chk("t1_other_ch", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3] - others), 32'd0);
        btn_in[0] = 1'b1;
        tick(40);

        // 2: short pulse filtered, longer pulse accepted
        base = press_cnt[1];
        btn_in[1] = 1'b0; tick(19);
        btn_in[1] = 1'b1; tick(30);
        chk("t2_short_press", 32'(press_cnt[1] - base), 32'd0);
        chk("t2_short_level", 32'(btn_level[1]), 32'd0);
        rb = rel_cnt[1];
        btn_in[1] = 1'b0; tick(22);
        btn_in[1] = 1'b1; tick(40);
        chk("t2_long_press", 32'(press_cnt[1] - base), 32'd1);
        chk("t2_release", 32'(rel_cnt[1] - rb), 32'd1);

        // 3: long press and auto-repeat on channel 2
        base = press_cnt[2];
        lb = long_cnt[2];
        rb = rep_cnt[2];
        btn_in[2] = 1'b0;
        wait_evt(0, 2, base, "t3_press");
        tp = press_t[2];
        tick(300);
        chk("t3_long_delay", 32'(long_t[2] - tp), 32'd100);
        chk("t3_repeat_count", 32'(rep_cnt[2] - rb), 32'd4);
        chk("t3_last_repeat", 32'(rep_t[2] - tp), 32'd300);
        base = rel_cnt[2];
        btn_in[2] = 1'b1;
        wait_evt(1, 2, base, "t3_release");
        tick(150);
        chk("t3_no_more_repeat", 32'(rep_cnt[2] - rb), 32'd4);
        chk("t3_long_once", 32'(long_cnt[2] - lb), 32'd1);

        // 4: simultaneous presses on channels 0 and 3
        base = press_cnt[0];
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        wait_evt(0, 0, base, "t4_press");
        chk("t4_press_vec", 32'(last_press_vec), 32'b1001);
        chk("t4_same_cycle", 32'(press_t[3] - press_t[0]), 32'd0);
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        tick(40);

        // 5: reset while channel 2 is mid-hold
        base = press_cnt[2];
        btn_in[2] = 1'b0;
        wait_evt(0, 2, base, "t5_press");
        tp = press_t[2];
        tick(50);
        rb = rel_cnt[2];
        rst = 1'b1;
        tick(1);
        r_edge = cyc;
        chk("t5_rst_outputs", 32'({btn_level, press_flag, release_flag, long_flag, repeat_flag}), 32'd0);
        rst = 1'b0;
        base = press_cnt[2];
        lb = long_cnt[2];
        wait_evt(0, 2, base, "t5_repress");
        chk("t5_repress_latency", 32'(press_t[2] - (r_edge + 1)), 32'd21);
        chk("t5_no_release", 32'(rel_cnt[2] - rb), 32'd0);
        wait_evt(2, 2, lb, "t5_long");
        chk("t5_long_delay", 32'(long_t[2] - press_t[2]), 32'd100);
        btn_in[2] = 1'b1;
        tick(40);

        // 6: release accepted on the long-press terminal cycle
        base = press_cnt[2];
        lb = long_cnt[2];
        rb = rel_cnt[2];
        btn_in[2] = 1'b0;
        wait_evt(0, 2, base, "t6_press");
        tp = press_t[2];
        tick(78);
        btn_in[2] = 1'b1;
        wait_evt(1, 2, rb, "t6_release");
        chk("t6_release_time", 32'(rel_t[2] - tp), 32'd100);
        tick(5);
        chk("t6_long_suppressed", 32'(long_cnt[2] - lb), 32'd0);
        tick(40);

        // Randomized activity checked cycle-by-cycle against the model
        for (int k = 0; k < 60; k++) begin
            btn_in = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick($urandom_range(1, 70));
        end
        btn_in = '1;
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
